// File: rtl/wb_dram_arbiter.sv
// Two-master Wishbone arbiter feeding the DRAM Wishbone adapter.
// Round-robin on ties, no preemption of a granted cycle, and a watchdog that
// force-terminates a strobe the slave never acknowledges. The watchdog answers
// such a strobe with an error word of 32'hFFFFFFFF and sets a sticky flag.
module wb_dram_arbiter #(
  parameter int AW      = 36,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  // master 0
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  output logic [31:0]   m0_dat_o,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_stb_i,
  input  logic          m0_cyc_i,
  output logic          m0_ack_o,
  // master 1
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  output logic [31:0]   m1_dat_o,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_stb_i,
  input  logic          m1_cyc_i,
  output logic          m1_ack_o,
  // slave side
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_stb_o,
  output logic          s_cyc_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i,
  // status
  output logic [1:0]    gnt_o,
  input  logic          timeout_clr_i,
  output logic          timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // Last counter value tolerated without an ack; one more silent cycle aborts.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          gsel_q, gsel_d;      // index of the granted master
  logic          last_q, last_d;      // master granted most recently (tie breaker)
  logic [15:0]   cnt_q, cnt_d;        // no-ack watchdog
  logic          timeout_q, timeout_d;

  // Request of the currently granted master
  logic [AW-1:0] g_adr;
  logic [31:0]   g_dat;
  logic [3:0]    g_sel;
  logic          g_we, g_stb, g_cyc;
  logic [1:0]    gnt_onehot;

  // Response routed back to the granted master
  logic          ack_g;
  logic [31:0]   rdat_g;

  assign g_adr      = gsel_q ? m1_adr_i : m0_adr_i;
  assign g_dat      = gsel_q ? m1_dat_i : m0_dat_i;
  assign g_sel      = gsel_q ? m1_sel_i : m0_sel_i;
  assign g_we       = gsel_q ? m1_we_i  : m0_we_i;
  assign g_stb      = gsel_q ? m1_stb_i : m0_stb_i;
  assign g_cyc      = gsel_q ? m1_cyc_i : m0_cyc_i;
  assign gnt_onehot = gsel_q ? 2'b10 : 2'b01;

  // The sticky flag is masked while reset is held so every output is idle.
  assign timeout_o  = timeout_q & ~reset;

  // State, grant, tie pointer, watchdog and sticky flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gsel_q    <= 1'b0;
      last_q    <= 1'b1;     // master 0 wins the first tie
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gsel_q    <= gsel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state: arbitrate in IDLE, hold while cyc stays high, abort on watchdog
  always_comb begin
    state_d = state_q;
    gsel_d  = gsel_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          // On a tie the master that did not own the bus last time wins.
          gsel_d  = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
          last_d  = gsel_d;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
        end else if (g_stb && !s_ack_i && (cnt_q == CNT_LAST)) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Watchdog counts silent strobe cycles; sticky flag set wins over clear
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if ((state_q != ST_BUSY) || !g_stb || s_ack_i) begin
      cnt_d = '0;
    end
    timeout_d = (state_q == ST_ABORT) | (timeout_q & ~timeout_clr_i);
  end

  // Outputs: pass the granted request through, route the response back
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    gnt_o    = 2'b00;
    ack_g    = 1'b0;
    rdat_g   = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (!reset) begin
      case (state_q)
        ST_BUSY: begin
          s_adr_o = g_adr;
          s_dat_o = g_dat;
          s_sel_o = g_sel;
          s_we_o  = g_we;
          s_stb_o = g_stb;
          s_cyc_o = g_cyc;
          gnt_o   = gnt_onehot;
          ack_g   = s_ack_i;
          rdat_g  = s_dat_i;
        end
        ST_ABORT: begin
          // Bus released toward the slave; a late slave ack is dropped here.
          s_adr_o = g_adr;
          s_dat_o = g_dat;
          s_sel_o = g_sel;
          s_we_o  = g_we;
          gnt_o   = gnt_onehot;
          ack_g   = 1'b1;
          rdat_g  = 32'hFFFF_FFFF;
        end
        default: ;
      endcase
      m0_ack_o = ack_g & ~gsel_q;
      m1_ack_o = ack_g &  gsel_q;
      m0_dat_o = gsel_q ? 32'h0 : rdat_g;
      m1_dat_o = gsel_q ? rdat_g : 32'h0;
    end
  end

endmodule
